// File: rtl/cache_sram_init_if.sv
// Tag/meta SRAM port bundle: cache_ctrl request fields on one side, the
// fields driven into the tag/meta SRAM macros on the other.
interface cache_sram_init_if #(
    parameter int NUM_WAYS = 4,
    parameter int AW       = 7
);
    logic [AW-1:0]       ctrl_tag_addr;
    logic [21:0]         ctrl_tag_wdat;
    logic [NUM_WAYS-1:0] ctrl_tag_web;
    logic [31:0]         ctrl_meta_wdat;
    logic [3:0]          ctrl_meta_wmask;
    logic                ctrl_meta_web;

    logic [AW-1:0]       tag_addr;
    logic [21:0]         tag_wdat;
    logic [NUM_WAYS-1:0] tag_web;
    logic [AW-1:0]       meta_addr;
    logic [31:0]         meta_wdat;
    logic [3:0]          meta_wmask;
    logic                meta_web;

    modport master (
        input  ctrl_tag_addr, ctrl_tag_wdat, ctrl_tag_web,
        input  ctrl_meta_wdat, ctrl_meta_wmask, ctrl_meta_web,
        output tag_addr, tag_wdat, tag_web,
        output meta_addr, meta_wdat, meta_wmask, meta_web
    );

    modport slave (
        output ctrl_tag_addr, ctrl_tag_wdat, ctrl_tag_web,
        output ctrl_meta_wdat, ctrl_meta_wmask, ctrl_meta_web,
        input  tag_addr, tag_wdat, tag_web,
        input  meta_addr, meta_wdat, meta_wmask, meta_web
    );
endinterface

// File: rtl/cache_sram_init.sv
// Tag/meta SRAM init/flush sequencer: owns the SRAM port while sweeping every
// set to zero, otherwise passes the cache_ctrl port straight through.
module cache_sram_init_chk #(
    parameter int NUM_WAYS = 4
) (
    input logic                clk,
    input logic                reset,
    input logic                flush_busy,
    input logic                flush_done,
    input logic                ctrl_hold,
    input logic [NUM_WAYS-1:0] tag_web,
    input logic                meta_web,
    input logic [21:0]         tag_wdat,
    input logic [31:0]         meta_wdat
);
    localparam logic [NUM_WAYS-1:0] WEB_OFF = {NUM_WAYS{1'b1}};
    localparam logic [NUM_WAYS-1:0] WEB_ALL = {NUM_WAYS{1'b0}};

    a_hold_is_busy: assert property (@(posedge clk) disable iff (reset)
        ctrl_hold == flush_busy);

    a_done_inside_busy: assert property (@(posedge clk) disable iff (reset)
        flush_done |-> flush_busy);

    a_done_one_cycle: assert property (@(posedge clk) disable iff (reset)
        flush_done |=> !flush_done);

    // While the sequencer owns the port, any write must be a full zero write.
    a_owned_writes_zero: assert property (@(posedge clk) disable iff (reset)
        (flush_busy && (tag_web != WEB_OFF)) |->
            ((tag_web == WEB_ALL) && (meta_web == 1'b0) &&
             (tag_wdat == 22'd0) && (meta_wdat == 32'd0)));
endmodule

module cache_sram_init #(
    parameter int NUM_WAYS = 4,
    parameter int SETS     = 128,
    parameter int AW       = $clog2(SETS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush_req_i,
    output logic              flush_busy_o,
    output logic              flush_done_o,
    output logic              ctrl_hold_o,
    input  logic              ctrl_idle_i,
    cache_sram_init_if.master bus
);
    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_SWEEP = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [AW-1:0]       LAST_SET = AW'(SETS - 1);
    localparam logic [NUM_WAYS-1:0] WEB_OFF  = {NUM_WAYS{1'b1}};
    localparam logic [NUM_WAYS-1:0] WEB_ALL  = {NUM_WAYS{1'b0}};

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_cnt;
    logic [AW-1:0] w_cnt_nxt;
    logic          r_pending;
    logic          w_pending_nxt;
    logic          r_busy;
    logic          r_done;

    // State, set counter, pending flag and status flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_INIT;
            r_cnt     <= {AW{1'b0}};
            r_pending <= 1'b0;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_pending <= w_pending_nxt;
            r_busy    <= (w_state_nxt != ST_IDLE);
            r_done    <= (w_state_nxt == ST_DONE);
        end
    end

    // Next-state, counter and pending-flag decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_pending_nxt = r_pending;
        case (r_state)
            ST_INIT: begin
                w_state_nxt = ST_SWEEP;
            end
            ST_IDLE: begin
                if (flush_req_i) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (ctrl_idle_i) begin
                    w_state_nxt = ST_SWEEP;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_SWEEP: begin
                if (flush_req_i) begin
                    w_pending_nxt = 1'b1;
                end else begin
                    w_pending_nxt = r_pending;
                end
                if (r_cnt == LAST_SET) begin
                    w_state_nxt = ST_DONE;
                    w_cnt_nxt   = {AW{1'b0}};
                end else begin
                    w_state_nxt = ST_SWEEP;
                    w_cnt_nxt   = r_cnt + AW'(1'b1);
                end
            end
            ST_DONE: begin
                // A request arriving in DONE itself chains straight into DRAIN.
                if (r_pending || flush_req_i) begin
                    w_state_nxt   = ST_DRAIN;
                    w_pending_nxt = 1'b0;
                end else begin
                    w_state_nxt   = ST_IDLE;
                    w_pending_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt   = ST_INIT;
                w_cnt_nxt     = {AW{1'b0}};
                w_pending_nxt = 1'b0;
            end
        endcase
    end

    // SRAM port mux: cache_ctrl pass-through in IDLE, sweep path otherwise.
    always_comb begin
        bus.tag_addr   = r_cnt;
        bus.meta_addr  = r_cnt;
        bus.tag_wdat   = 22'd0;
        bus.meta_wdat  = 32'd0;
        bus.meta_wmask = 4'b1111;
        bus.tag_web    = WEB_OFF;
        bus.meta_web   = 1'b1;
        if (r_state == ST_IDLE) begin
            bus.tag_addr   = bus.ctrl_tag_addr;
            bus.meta_addr  = bus.ctrl_tag_addr;
            bus.tag_wdat   = bus.ctrl_tag_wdat;
            bus.meta_wdat  = bus.ctrl_meta_wdat;
            bus.meta_wmask = bus.ctrl_meta_wmask;
            bus.tag_web    = bus.ctrl_tag_web;
            bus.meta_web   = bus.ctrl_meta_web;
        end else if (r_state == ST_SWEEP) begin
            bus.tag_web    = WEB_ALL;
            bus.meta_web   = 1'b0;
        end else begin
            bus.tag_web    = WEB_OFF;
            bus.meta_web   = 1'b1;
        end
    end

    assign flush_busy_o = r_busy;
    assign ctrl_hold_o  = r_busy;
    assign flush_done_o = r_done;

    cache_sram_init_chk #(
        .NUM_WAYS (NUM_WAYS)
    ) u_chk (
        .clk        (clk),
        .reset      (reset),
        .flush_busy (flush_busy_o),
        .flush_done (flush_done_o),
        .ctrl_hold  (ctrl_hold_o),
        .tag_web    (bus.tag_web),
        .meta_web   (bus.meta_web),
        .tag_wdat   (bus.tag_wdat),
        .meta_wdat  (bus.meta_wdat)
    );
endmodule

// File: tb/tb_cache_sram_init.sv
// Scoreboard bench for cache_sram_init: stimulus queues expected SRAM writes,
// done pulses and status samples; a negedge monitor pops and compares.
module tb_cache_sram_init;
    localparam int NUM_WAYS = 4;
    localparam int SETS     = 128;
    localparam int AW       = 7;

    typedef struct {
        int                  cyc;
        logic [AW-1:0]       addr;
        logic [NUM_WAYS-1:0] tag_web;
        logic [21:0]         tag_wdat;
        logic                meta_web;
        logic [31:0]         meta_wdat;
        logic [3:0]          meta_wmask;
    } wr_t;

    typedef struct {
        int   cyc;
        logic hold;
        logic done;
        bit   rst_chk;
        bit   final_chk;
    } st_t;

    logic clk;
    logic reset;
    logic flush_req;
    logic flush_busy;
    logic flush_done;
    logic ctrl_hold;
    logic ctrl_idle;

    cache_sram_init_if #(.NUM_WAYS(NUM_WAYS), .AW(AW)) bus ();

    cache_sram_init #(
        .NUM_WAYS (NUM_WAYS),
        .SETS     (SETS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .flush_req_i  (flush_req),
        .flush_busy_o (flush_busy),
        .flush_done_o (flush_done),
        .ctrl_hold_o  (ctrl_hold),
        .ctrl_idle_i  (ctrl_idle),
        .bus          (bus)
    );

    wr_t exp_q[$];
    int  done_q[$];
    st_t st_q[$];
    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(int target);
        while (cyc < target) tick();
    endtask

    // A full sweep: one all-ways zero write per set, in order, then a done pulse.
    task automatic push_sweep(int first);
        wr_t w;
        for (int k = 0; k < SETS; k++) begin
            w.cyc        = first + k;
            w.addr       = AW'(k);
            w.tag_web    = {NUM_WAYS{1'b0}};
            w.tag_wdat   = 22'd0;
            w.meta_web   = 1'b0;
            w.meta_wdat  = 32'd0;
            w.meta_wmask = 4'b1111;
            exp_q.push_back(w);
        end
        done_q.push_back(first + SETS);
    endtask

    task automatic push_st(int c, logic h, logic d, bit r, bit f);
        st_t s;
        s.cyc = c; s.hold = h; s.done = d; s.rst_chk = r; s.final_chk = f;
        st_q.push_back(s);
    endtask

    task automatic quiet_ctrl();
        bus.ctrl_tag_addr   = 7'd0;
        bus.ctrl_tag_wdat   = 22'd0;
        bus.ctrl_tag_web    = {NUM_WAYS{1'b1}};
        bus.ctrl_meta_wdat  = 32'd0;
        bus.ctrl_meta_wmask = 4'd0;
        bus.ctrl_meta_web   = 1'b1;
    endtask

    task automatic rand_ctrl(bit force_wr);
        bus.ctrl_tag_addr   = AW'($urandom_range(0, SETS - 1));
        bus.ctrl_tag_wdat   = 22'($urandom);
        bus.ctrl_tag_web    = force_wr ? {NUM_WAYS{1'b0}} : NUM_WAYS'($urandom);
        bus.ctrl_meta_wdat  = 32'($urandom);
        bus.ctrl_meta_wmask = 4'($urandom);
        bus.ctrl_meta_web   = force_wr ? 1'b0 : 1'($urandom);
    endtask

    // In IDLE whatever cache_ctrl drives is exactly what the SRAM sees this cycle.
    task automatic push_ctrl_if_write();
        wr_t w;
        if (bus.ctrl_tag_web != {NUM_WAYS{1'b1}} || bus.ctrl_meta_web == 1'b0) begin
            w.cyc        = cyc;
            w.addr       = bus.ctrl_tag_addr;
            w.tag_web    = bus.ctrl_tag_web;
            w.tag_wdat   = bus.ctrl_tag_wdat;
            w.meta_web   = bus.ctrl_meta_web;
            w.meta_wdat  = bus.ctrl_meta_wdat;
            w.meta_wmask = bus.ctrl_meta_wmask;
            exp_q.push_back(w);
        end
    endtask

    task automatic idle_traffic(int n);
        repeat (n) begin
            tick();
            rand_ctrl(1'b0);
            push_ctrl_if_write();
        end
        tick();
        quiet_ctrl();
    endtask

    task automatic back_to_back(int j);
        int t;
        tick();
        flush_req = 1'b1;
        t = cyc;
        push_sweep(t + 2);
        tick();
        flush_req = 1'b0;
        wait_cyc(t + 2 + j);
        flush_req = 1'b1;
        push_sweep(t + SETS + 4);
        push_st(t + SETS + 2, 1'b1, 1'b1, 1'b0, 1'b0);
        push_st(t + SETS + 3, 1'b1, 1'b0, 1'b0, 1'b0);
        push_st(t + 2 * SETS + 4, 1'b1, 1'b1, 1'b0, 1'b0);
        push_st(t + 2 * SETS + 5, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        flush_req = 1'b0;
        wait_cyc(t + 2 * SETS + 6);
    endtask

    // Monitor / scoreboard.
    initial begin : monitor
        wr_t e;
        int  d;
        st_t s;
        forever begin
            @(negedge clk);
            checks++;
            if (flush_busy !== ctrl_hold) begin
                errors++;
                $display("FAIL hold_vs_busy cyc=%0d hold=%b busy=%b required equal", cyc, ctrl_hold, flush_busy);
            end
            if (bus.tag_web !== {NUM_WAYS{1'b1}} || bus.meta_web !== 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write cyc=%0d addr=%h tag_web=%b tag=%h meta_web=%b meta=%h required no write",
                             cyc, bus.tag_addr, bus.tag_web, bus.tag_wdat, bus.meta_web, bus.meta_wdat);
                end else begin
                    e = exp_q.pop_front();
                    if (cyc != e.cyc || bus.tag_addr !== e.addr || bus.meta_addr !== e.addr ||
                        bus.tag_web !== e.tag_web || bus.tag_wdat !== e.tag_wdat ||
                        bus.meta_web !== e.meta_web || bus.meta_wdat !== e.meta_wdat ||
                        bus.meta_wmask !== e.meta_wmask) begin
                        errors++;
                        $display("FAIL sram_write got cyc=%0d addr=%h/%h tag_web=%b tag=%h meta_web=%b meta=%h mask=%b required cyc=%0d addr=%h tag_web=%b tag=%h meta_web=%b meta=%h mask=%b",
                                 cyc, bus.tag_addr, bus.meta_addr, bus.tag_web, bus.tag_wdat, bus.meta_web,
                                 bus.meta_wdat, bus.meta_wmask, e.cyc, e.addr, e.tag_web, e.tag_wdat,
                                 e.meta_web, e.meta_wdat, e.meta_wmask);
                    end
                end
            end
            if (flush_done === 1'b1) begin
                checks++;
                if (done_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done cyc=%0d required no pulse", cyc);
                end else begin
                    d = done_q.pop_front();
                    if (d != cyc) begin
                        errors++;
                        $display("FAIL done_cycle got %0d required %0d", cyc, d);
                    end
                end
            end
            while (st_q.size() > 0 && st_q[0].cyc <= cyc) begin
                s = st_q.pop_front();
                checks++;
                if (s.cyc != cyc || ctrl_hold !== s.hold || flush_done !== s.done) begin
                    errors++;
                    $display("FAIL status cyc=%0d hold=%b done=%b required cyc=%0d hold=%b done=%b",
                             cyc, ctrl_hold, flush_done, s.cyc, s.hold, s.done);
                end
                if (s.rst_chk) begin
                    checks++;
                    if (bus.tag_web !== {NUM_WAYS{1'b1}} || bus.meta_web !== 1'b1 ||
                        bus.tag_addr !== 7'd0 || bus.meta_addr !== 7'd0 || flush_busy !== 1'b1) begin
                        errors++;
                        $display("FAIL reset_outputs tag_web=%b meta_web=%b addr=%h/%h busy=%b required 1111 1 00/00 1",
                                 bus.tag_web, bus.meta_web, bus.tag_addr, bus.meta_addr, flush_busy);
                    end
                end
                if (s.final_chk) begin
                    checks++;
                    if (exp_q.size() != 0 || done_q.size() != 0) begin
                        errors++;
                        $display("FAIL leftover_expected writes=%0d dones=%0d required 0 0", exp_q.size(), done_q.size());
                    end
                end
            end
        end
    end

    // Stimulus.
    initial begin : stim
        int c0;
        int t;
        int r;
        reset     = 1'b1;
        flush_req = 1'b0;
        ctrl_idle = 1'b1;
        quiet_ctrl();
        push_st(1, 1'b1, 1'b0, 1'b1, 1'b0);
        push_st(2, 1'b1, 1'b0, 1'b1, 1'b0);

        // Reset init sweep.
        repeat (3) @(negedge clk);
        #1;
        reset = 1'b0;
        c0 = cyc;
        push_sweep(c0 + 1);
        push_st(c0 + SETS + 1, 1'b1, 1'b1, 1'b0, 1'b0);
        push_st(c0 + SETS + 2, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_cyc(c0 + SETS + 3);

        // Fixed pass-through pattern, then random IDLE traffic.
        bus.ctrl_tag_addr   = 7'h2A;
        bus.ctrl_tag_web    = 4'b1101;
        bus.ctrl_tag_wdat   = 22'h20_0013;
        bus.ctrl_meta_web   = 1'b1;
        bus.ctrl_meta_wdat  = 32'($urandom);
        bus.ctrl_meta_wmask = 4'($urandom);
        push_ctrl_if_write();
        idle_traffic(20);

        // Flush with ctrl writes hammering the port; a repeat request in DRAIN is absorbed.
        flush_req = 1'b1;
        t = cyc;
        push_sweep(t + 2);
        push_st(t + SETS + 2, 1'b1, 1'b1, 1'b0, 1'b0);
        push_st(t + SETS + 3, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        rand_ctrl(1'b1);
        tick();
        flush_req = 1'b0;
        while (cyc <= t + SETS + 2) begin
            rand_ctrl(1'b1);
            tick();
        end
        quiet_ctrl();
        tick();

        // Drain wait: cache_ctrl busy for 5 cycles.
        ctrl_idle = 1'b0;
        flush_req = 1'b1;
        t = cyc;
        for (int k = 1; k <= 5; k++) push_st(t + k, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        flush_req = 1'b0;
        while (cyc < t + 5) begin
            rand_ctrl(1'b1);
            tick();
        end
        ctrl_idle = 1'b1;
        r = cyc;
        push_sweep(r + 1);
        push_st(r + SETS + 1, 1'b1, 1'b1, 1'b0, 1'b0);
        push_st(r + SETS + 2, 1'b0, 1'b0, 1'b0, 1'b0);
        while (cyc < r + SETS + 2) begin
            rand_ctrl(1'b1);
            tick();
        end
        quiet_ctrl();

        // Back-to-back flushes: mid-sweep, random, last sweep cycle, DONE cycle.
        back_to_back(40);
        back_to_back($urandom_range(0, SETS));
        back_to_back(SETS - 1);
        back_to_back(SETS);

        // Reset asserted while the sweep is writing set 60.
        tick();
        flush_req = 1'b1;
        t = cyc;
        push_sweep(t + 2);
        tick();
        flush_req = 1'b0;
        wait_cyc(t + 62);
        reset = 1'b1;
        exp_q.delete();
        done_q.delete();
        push_st(cyc, 1'b1, 1'b0, 1'b1, 1'b0);
        push_st(cyc + 1, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        tick();
        @(negedge clk);
        #1;
        reset = 1'b0;
        c0 = cyc;
        push_sweep(c0 + 1);
        push_st(c0 + SETS + 1, 1'b1, 1'b1, 1'b0, 1'b0);
        push_st(c0 + SETS + 2, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_cyc(c0 + SETS + 3);

        idle_traffic(20);
        push_st(cyc + 2, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (4) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cache_sram_init.md
# cache_sram_init

Sequencer that owns the tag/meta SRAM port of the L1 cache during initialisation and flush, and otherwise passes the `cache_ctrl` port straight through. After reset, and on each flush request, it stalls `cache_ctrl`, waits for it to drain, then sweeps every set. The sweep writes a zero tag (valid bit 21 cleared) into all ways and zeroes the meta word. It sits between `cache_ctrl` and the tag/meta SRAM macros (ahead of the scan mux) inside the cache top.

## Interface
- `NUM_WAYS`, 4, number of ways (tag SRAM write enables).
- `SETS`, 128, number of sets; `AW = $clog2(SETS)` is the set address width.
- `clk` in 1: single clock for all state.
- `reset` in 1: asynchronous, active-high reset.
- `flush_req_i` in 1: flush request, level or pulse, sampled every cycle.
- `flush_busy_o` out 1: high whenever state != IDLE.
- `flush_done_o` out 1: one-cycle pulse at end of each sweep.
- `ctrl_hold_o` out 1: stall to `cache_ctrl` (gates `p0_urdy`); high whenever state != IDLE.
- `ctrl_idle_i` in 1: `cache_ctrl` has no outstanding access.
- `ctrl_tag_addr_i` in AW: `cache_ctrl` tag/meta set address.
- `ctrl_tag_wdat_i` in 22: `cache_ctrl` tag write data.
- `ctrl_tag_web_i` in NUM_WAYS: `cache_ctrl` tag write enables, active-low.
- `ctrl_meta_wdat_i` in 32: `cache_ctrl` meta write data.
- `ctrl_meta_wmask_i` in 4: `cache_ctrl` meta byte mask.
- `ctrl_meta_web_i` in 1: `cache_ctrl` meta write enable, active-low.
- `tag_addr_o` out AW: SRAM-side tag address.
- `tag_wdat_o` out 22: SRAM-side tag write data.
- `tag_web_o` out NUM_WAYS: SRAM-side tag write enables, active-low.
- `meta_addr_o` out AW: SRAM-side meta address.
- `meta_wdat_o` out 32: SRAM-side meta write data.
- `meta_wmask_o` out 4: SRAM-side meta byte mask.
- `meta_web_o` out 1: SRAM-side meta write enable, active-low.

## Operation
- States: INIT, IDLE, DRAIN, SWEEP, DONE.
- Registers: set counter `cnt[AW-1:0]` and a `pending` flag.
- **INIT** (reset state):
  - SRAM outputs are the sweep path with all write enables high; no write occurs.
  - Next state is unconditionally SWEEP.
- **IDLE**:
  - Pure combinational pass-through: each `ctrl_*` input appears on the matching SRAM output.
  - `flush_req_i`=1 moves to DRAIN.
- **DRAIN**:
  - All SRAM write enables are high.
  - Stay while `ctrl_idle_i`=0; move to SWEEP when `ctrl_idle_i`=1.
- **SWEEP**:
  - `tag_addr_o` = `meta_addr_o` = `cnt`.
  - `tag_wdat_o`=0, `tag_web_o`=all zeros.
  - `meta_wdat_o`=0, `meta_wmask_o`=4'b1111, `meta_web_o`=0.
  - `cnt` increments each cycle. At `cnt`==SETS-1: move to DONE and `cnt` wraps to 0.
- **DONE**:
  - All write enables are high; `flush_done_o`=1.
  - If `pending`=1: go to DRAIN and clear `pending`; otherwise go to IDLE.
- **`pending` flag**:
  - Set when `flush_req_i`=1 in SWEEP or DONE; cleared only on the DONE->DRAIN transition.
  - A request in INIT or DRAIN is absorbed by the sweep already scheduled and does not set `pending`.
- **Masking**: in every state other than IDLE, `ctrl_*` write inputs are ignored and never reach the SRAM.
- **Address in non-sweep, non-IDLE states**: `tag_addr_o` and `meta_addr_o` = `cnt`.

## Timing
- **Reset values**:
  - state=INIT, `cnt`=0, `pending`=0.
  - `flush_busy_o`=1, `ctrl_hold_o`=1, `flush_done_o`=0.
  - All `*_web_o` outputs high, `tag_addr_o`=`meta_addr_o`=0.
- **After reset deassert** (cycle 0 = first cycle after deassert):
  - INIT on cycle 0.
  - SWEEP writes on cycles 1..SETS (sets 0..SETS-1).
  - DONE on cycle SETS+1.
  - IDLE, with hold low, on cycle SETS+2.
- **Flush latency**: request in IDLE on cycle t → DRAIN at t+1.
- **Sweep length**: exactly SETS write cycles; every write covers all ways plus meta.
- **Outputs**: `flush_busy_o`, `ctrl_hold_o` and `flush_done_o` are decoded from the state register only (no input-to-output paths). The only combinational paths are the IDLE pass-through.
- **Reset mid-operation**: returns to INIT asynchronously. `cnt` and `pending` clear, write enables go high immediately, and the full sweep is reissued.
- **Simultaneous events**:
  - `flush_req_i` together with the last SWEEP cycle sets `pending`.
  - `flush_req_i` together with DONE sets `pending`, so DONE goes to DRAIN with no IDLE cycle.

## Test plan
- **Reset init**: deassert reset with `ctrl_idle_i`=1.
  - Exactly 128 writes on cycles 1..128 at addresses 0..127, with `tag_web_o`=4'b0000, `tag_wdat_o`=0 and `meta_wdat_o`=0.
  - `flush_done_o` pulses on cycle 129; `ctrl_hold_o` falls on cycle 130.
- **Pass-through**: in IDLE drive `ctrl_tag_addr_i`=7'h2A, `ctrl_tag_web_i`=4'b1101, `ctrl_tag_wdat_i`=22'h20_0013.
  - Identical values appear on the SRAM outputs in the same cycle.
- **Drain wait**: pulse `flush_req_i` with `ctrl_idle_i`=0 for 5 cycles.
  - State holds in DRAIN, `ctrl_hold_o`=1 and no SRAM writes.
  - The sweep starts the cycle after `ctrl_idle_i` rises.
- **Back-to-back flush**: assert `flush_req_i` during the SWEEP at `cnt`=40.
  - After DONE the block goes to DRAIN (no IDLE cycle), then performs a second 128-write sweep.
  - `flush_done_o` pulses twice.
- **Reset mid-sweep**: assert reset at `cnt`=60.
  - Write enables go high immediately.
  - After deassert, the sweep restarts at address 0 and completes 128 writes.
- **Masking**: drive `ctrl_tag_web_i`=0 and `ctrl_meta_web_i`=0 throughout a flush.
  - No SRAM write carries `ctrl_*` data; the only writes observed are the 128 zero writes.
